tdm_clock_gen: RTL and testbench

- Runtime-configurable bit-clock and frame-sync generator for I2S, left-justified and DSP/TDM audio links.
- Supports 2..MAX_SLOTS slots of programmable width.
- Provides bit/slot position strobes so serializers and deserializers can run in the clk_i domain.
- Stops gracefully at a frame boundary when disabled; sits between the control register file and the audio TX/RX shift engines.

---
 rtl/tdm_clk_pkg.sv | 32 +++
 rtl/tdm_sck_div.sv | 46 ++++
 rtl/tdm_clock_gen.sv | 168 ++++++++++++++++
 tb/tb_tdm_clock_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_clk_pkg.sv
// Shared types, limits and the fs decode helper for the TDM/I2S bit-clock generator.
package tdm_clk_pkg;

    typedef enum logic [1:0] {
        MODE_LJ   = 2'd0,
        MODE_I2S  = 2'd1,
        MODE_DSP  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int MIN_DIV       = 2;
    localparam int MIN_SLOT_BITS = 8;
    localparam int MIN_SLOTS     = 2;

    // DSP pulses for slot 0 MSB only; LJ/I2S hold fs_pol for the first half of the frame.
    function automatic logic fs_level(input mode_e mode, input logic first_half,
                                      input logic frame_start, input logic fs_pol);
        if (mode == MODE_DSP) return frame_start;
        return first_half ? fs_pol : ~fs_pol;
    endfunction

    function automatic logic fs_idle(input mode_e mode, input logic fs_pol);
        return (mode == MODE_DSP) ? 1'b0 : ~fs_pol;
    endfunction

endpackage

// File: rtl/tdm_sck_div.sv
// SCK phase counter: low for div - div/2 cycles, then high for div/2 cycles.
module tdm_sck_div #(
    parameter int DIV_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             clear_i,
    output logic             sck_o,
    output logic             fall_o,
    output logic             fall_next_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_n;
    logic [DIV_W-1:0] low_len;

    always_comb begin
        low_len     = div_i - (div_i >> 1);
        cnt_n       = (cnt_q >= div_i - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
        fall_next_o = run_i && (cnt_n == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sck_o  <= 1'b0;
            fall_o <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= '0;
            sck_o  <= 1'b0;
            fall_o <= 1'b1;
        end else if (clear_i || !run_i) begin
            cnt_q  <= '0;
            sck_o  <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            sck_o  <= (cnt_n >= low_len);
            fall_o <= (cnt_n == '0);
        end
    end

endmodule

// File: rtl/tdm_clock_gen.sv
// Bit-clock / frame-sync generator for LJ, I2S and DSP/TDM links with bit and slot strobes.
module tdm_clock_gen
    import tdm_clk_pkg::*;
#(
    parameter int   MAX_DIV    = 64,
    parameter int   SLOT_W_MAX = 32,
    parameter int   MAX_SLOTS  = 8,
    parameter logic FS_POL     = 1'b0,
    localparam int  DIV_W      = $clog2(MAX_DIV + 1),
    localparam int  SB_W       = $clog2(SLOT_W_MAX + 1),
    localparam int  NS_W       = $clog2(MAX_SLOTS + 1),
    localparam int  BIT_W      = $clog2(SLOT_W_MAX),
    localparam int  SLOT_W     = $clog2(MAX_SLOTS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [SB_W-1:0]   slot_bits_i,
    input  logic [NS_W-1:0]   num_slots_i,
    input  logic [1:0]        mode_i,
    output logic              sck_o,
    output logic              fs_o,
    output logic              sck_fall_o,
    output logic [BIT_W-1:0]  bit_idx_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic              frame_start_o,
    output logic              busy_o,
    output logic              cfg_err_o
);

    state_e            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [SB_W-1:0]   sb_q;
    logic [NS_W-1:0]   ns_q;
    mode_e             mode_q;

    logic              fall_next;
    logic              cfg_ok, start, eob, eof, boundary, drain_stop, load, frame_new;
    logic [DIV_W-1:0]  div_n;
    logic [SB_W-1:0]   sb_n;
    logic [NS_W-1:0]   ns_n;
    mode_e             mode_n;
    logic [BIT_W-1:0]  bit_n;
    logic [SLOT_W-1:0] slot_n;
    logic [NS_W-1:0]   slot_la;
    logic              half_now, half_la, fs_n;

    always_comb begin
        cfg_ok = (div_i >= DIV_W'(MIN_DIV)) && (div_i <= DIV_W'(MAX_DIV))
              && (slot_bits_i >= SB_W'(MIN_SLOT_BITS)) && (slot_bits_i <= SB_W'(SLOT_W_MAX))
              && (num_slots_i >= NS_W'(MIN_SLOTS)) && (num_slots_i <= NS_W'(MAX_SLOTS))
              && (mode_i != MODE_RSVD)
              && ((mode_i == MODE_DSP) || !num_slots_i[0]);

        start      = (state_q == IDLE) && en_i && cfg_ok;
        eob        = (bit_idx_o == '0);
        eof        = eob && (NS_W'(slot_idx_o) == ns_q - NS_W'(1));
        boundary   = fall_next && eof;
        drain_stop = (state_q == DRAIN) && !en_i && boundary;
        load       = start || (boundary && !drain_stop && cfg_ok);
        frame_new  = start || boundary;

        div_n  = load ? div_i       : div_q;
        sb_n   = load ? slot_bits_i : sb_q;
        ns_n   = load ? num_slots_i : ns_q;
        mode_n = load ? mode_e'(mode_i) : mode_q;

        if (frame_new) begin
            slot_n = '0;
            bit_n  = BIT_W'(sb_n - SB_W'(1));
        end else if (eob) begin
            slot_n = slot_idx_o + SLOT_W'(1);
            bit_n  = BIT_W'(sb_n - SB_W'(1));
        end else begin
            slot_n = slot_idx_o;
            bit_n  = bit_idx_o - BIT_W'(1);
        end

        // Slot that owns the following bit; I2S fs runs one SCK ahead of the data.
        if (bit_n != '0) begin
            slot_la = NS_W'(slot_n);
        end else if (NS_W'(slot_n) == ns_n - NS_W'(1)) begin
            slot_la = '0;
        end else begin
            slot_la = NS_W'(slot_n) + NS_W'(1);
        end

        half_now = (NS_W'(slot_n) < (ns_n >> 1));
        half_la  = (slot_la < (ns_n >> 1));
        fs_n     = fs_level(mode_n, (mode_n == MODE_I2S) ? half_la : half_now, frame_new, FS_POL);
    end

    tdm_sck_div #(.DIV_W(DIV_W)) u_sck_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .div_i       (div_q),
        .start_i     (start),
        .run_i       (state_q != IDLE),
        .clear_i     (drain_stop),
        .sck_o       (sck_o),
        .fall_o      (sck_fall_o),
        .fall_next_o (fall_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            div_q         <= DIV_W'(MIN_DIV);
            sb_q          <= SB_W'(MIN_SLOT_BITS);
            ns_q          <= NS_W'(MIN_SLOTS);
            mode_q        <= MODE_LJ;
            bit_idx_o     <= '0;
            slot_idx_o    <= '0;
            fs_o          <= ~FS_POL;
            frame_start_o <= 1'b0;
            cfg_err_o     <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!en_i) begin
                        cfg_err_o <= 1'b0;
                    end else if (!cfg_ok) begin
                        cfg_err_o <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (en_i) begin
                        state_q <= RUN;
                    end else if (state_q == RUN) begin
                        state_q <= DRAIN;
                    end else if (drain_stop) begin
                        state_q <= IDLE;
                    end
                    if (boundary && !drain_stop && !cfg_ok) begin
                        cfg_err_o <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                div_q  <= div_n;
                sb_q   <= sb_n;
                ns_q   <= ns_n;
                mode_q <= mode_n;
            end

            if (drain_stop) begin
                bit_idx_o  <= '0;
                slot_idx_o <= '0;
                fs_o       <= fs_idle(mode_q, FS_POL);
            end else if (start || fall_next) begin
                bit_idx_o     <= bit_n;
                slot_idx_o    <= slot_n;
                fs_o          <= fs_n;
                frame_start_o <= frame_new;
            end
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_tdm_clock_gen.sv
// Directed checks of tdm_clock_gen: SCK shape, fs per mode, drain/stop, config errors, async reset.
module tb_tdm_clock_gen;

    localparam int DIV_W  = $clog2(64 + 1);
    localparam int SB_W   = $clog2(32 + 1);
    localparam int NS_W   = $clog2(8 + 1);
    localparam int BIT_W  = $clog2(32);
    localparam int SLOT_W = $clog2(8);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_i = 1'b0;
    logic [DIV_W-1:0]  div_i = '0;
    logic [SB_W-1:0]   slot_bits_i = '0;
    logic [NS_W-1:0]   num_slots_i = '0;
    logic [1:0]        mode_i = '0;
    logic              sck_o, fs_o, sck_fall_o, frame_start_o, busy_o, cfg_err_o;
    logic [BIT_W-1:0]  bit_idx_o;
    logic [SLOT_W-1:0] slot_idx_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SLOT_W-1:0] exp_q[$];

    tdm_clock_gen dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en_i),
        .div_i         (div_i),
        .slot_bits_i   (slot_bits_i),
        .num_slots_i   (num_slots_i),
        .mode_i        (mode_i),
        .sck_o         (sck_o),
        .fs_o          (fs_o),
        .sck_fall_o    (sck_fall_o),
        .bit_idx_o     (bit_idx_o),
        .slot_idx_o    (slot_idx_o),
        .frame_start_o (frame_start_o),
        .busy_o        (busy_o),
        .cfg_err_o     (cfg_err_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en_i = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        tick();
    endtask

    // driver tasks
    task automatic set_cfg(input int d, input int sb, input int ns, input int m);
        div_i       = DIV_W'(d);
        slot_bits_i = SB_W'(sb);
        num_slots_i = NS_W'(ns);
        mode_i      = 2'(m);
    endtask

    task automatic measure_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start_o && n < 2000);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int sck_a[160];
    int fall_a[160];
    int fs_a[160];
    int bit_a[160];
    int slot_a[160];

    initial begin
        int n, falls, hi, rise_c, fall_c, bad, fs_hi, fs_first, busy_low, fstarts;
        logic prev_fs;
        logic [SLOT_W-1:0] prev_slot;

        // reset values
        rst = 1'b1;
        tick();
        check("rst_sck", sck_o, 0);
        check("rst_fs", fs_o, 1);
        check("rst_fall", sck_fall_o, 0);
        check("rst_fstart", frame_start_o, 0);
        check("rst_bit", bit_idx_o, 0);
        check("rst_slot", slot_idx_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", cfg_err_o, 0);
        rst = 1'b0;
        tick();

        // stereo I2S, div 8, 32-bit slots: 512-cycle frame
        set_cfg(8, 32, 2, 1);
        en_i = 1'b1;
        tick();
        check("i2s_first_fall", sck_fall_o, 1);
        check("i2s_first_fstart", frame_start_o, 1);
        check("i2s_first_bit", bit_idx_o, 31);
        check("i2s_first_slot", slot_idx_o, 0);
        check("i2s_first_fs", fs_o, 0);
        check("i2s_first_sck", sck_o, 0);
        check("i2s_busy", busy_o, 1);
        falls = 0; hi = 0; rise_c = -1; fall_c = -1; prev_fs = fs_o;
        for (int c = 0; c < 512; c++) begin
            if (sck_fall_o) falls++;
            if (sck_o) hi++;
            if (c > 0 && fs_o && !prev_fs && rise_c < 0) rise_c = c;
            if (c > 0 && !fs_o && prev_fs && fall_c < 0) fall_c = c;
            prev_fs = fs_o;
            tick();
        end
        check("i2s_falls", falls, 64);
        check("i2s_sck_high", hi, 256);
        check("i2s_fs_rise", rise_c, 248);
        check("i2s_fs_fall", fall_c, 504);
        check("i2s_frame2_fstart", frame_start_o, 1);
        check("i2s_frame2_bit", bit_idx_o, 31);
        check("i2s_frame2_fs", fs_o, 0);

        // odd divider, LJ, div 5, 8-bit slots: 80-cycle frames
        do_reset();
        set_cfg(5, 8, 2, 0);
        en_i = 1'b1;
        tick();
        for (int c = 0; c < 160; c++) begin
            sck_a[c] = int'(sck_o);  fall_a[c] = int'(sck_fall_o); fs_a[c] = int'(fs_o);
            bit_a[c] = int'(bit_idx_o); slot_a[c] = int'(slot_idx_o);
            tick();
        end
        bad = 0; fstarts = 0;
        for (int p = 0; p < 32; p++) begin
            for (int k = 0; k < 5; k++) begin
                if (sck_a[5*p+k] != ((k >= 3) ? 1 : 0)) bad++;
                if (fall_a[5*p+k] != ((k == 0) ? 1 : 0)) bad++;
            end
        end
        check("odd_div_shape", bad, 0);
        check("lj_fs_c39", fs_a[39], 0);
        check("lj_fs_c40", fs_a[40], 1);
        check("lj_fs_c80", fs_a[80], 0);
        check("lj_bit_c35", bit_a[35], 0);
        check("lj_bit_c40", bit_a[40], 7);
        check("lj_slot_c40", slot_a[40], 1);

        // TDM8 DSP, div 4, 16-bit slots: 512-cycle frame
        do_reset();
        set_cfg(4, 16, 8, 2);
        en_i = 1'b1;
        tick();
        for (int s = 0; s < 8; s++) exp_q.push_back(SLOT_W'(s));
        fs_hi = 0; fs_first = -1; bad = 0; prev_slot = slot_idx_o;
        for (int c = 0; c < 512; c++) begin
            if (fs_o) begin
                fs_hi++;
                if (fs_first < 0) fs_first = c;
            end
            if (frame_start_o && c != 0) bad++;
            if (c == 0 || slot_idx_o != prev_slot) begin
                if (exp_q.size() > 0) check("dsp_slot_seq", slot_idx_o, exp_q.pop_front());
                else bad++;
            end
            prev_slot = slot_idx_o;
            tick();
        end
        check("dsp_fs_high", fs_hi, 4);
        check("dsp_fs_first", fs_first, 0);
        check("dsp_extra_events", bad, 0);
        check("dsp_slot_left", exp_q.size(), 0);
        check("dsp_frame2_fstart", frame_start_o, 1);
        check("dsp_frame2_fs", fs_o, 1);
        en_i = 1'b0;
        n = 0;
        while (busy_o && n < 2000) begin
            tick();
            n++;
        end
        check("dsp_drain_len", n, 512);
        check("dsp_idle_fs", fs_o, 0);
        check("dsp_idle_sck", sck_o, 0);

        // graceful stop from slot 1 bit 5
        do_reset();
        set_cfg(8, 32, 2, 1);
        en_i = 1'b1;
        tick();
        n = 0;
        while (!(sck_fall_o && slot_idx_o == 1 && bit_idx_o == 5) && n < 2000) begin
            tick();
            n++;
        end
        check("stop_reach_s1b5", n, 464);
        en_i = 1'b0;
        n = 0; falls = 0; hi = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
            if (sck_fall_o) falls++;
            if (sck_o) hi++;
        end
        check("stop_len", n, 48);
        check("stop_falls", falls, 5);
        check("stop_sck_high", hi, 24);
        check("stop_sck", sck_o, 0);
        check("stop_fall", sck_fall_o, 0);
        check("stop_fstart", frame_start_o, 0);
        check("stop_fs_idle", fs_o, 1);
        check("stop_bit", bit_idx_o, 0);

        // re-enable during drain: frame carries on
        en_i = 1'b1;
        tick();
        n = 0;
        while (!(sck_fall_o && slot_idx_o == 1 && bit_idx_o == 5) && n < 2000) begin
            tick();
            n++;
        end
        en_i = 1'b0;
        n = 0; busy_low = 0;
        while (n < 200) begin
            tick();
            n++;
            if (!busy_o) busy_low++;
            if (n == 10) en_i = 1'b1;
            if (frame_start_o) break;
        end
        check("redrain_len", n, 48);
        check("redrain_busy_low", busy_low, 0);
        check("redrain_bit", bit_idx_o, 31);

        // config errors in IDLE
        do_reset();
        set_cfg(8, 16, 3, 0);
        en_i = 1'b1;
        tick();
        check("err_ns3_busy", busy_o, 0);
        check("err_ns3_flag", cfg_err_o, 1);
        tick(); tick(); tick();
        check("err_ns3_sticky", cfg_err_o, 1);
        check("err_ns3_idle", busy_o, 0);
        en_i = 1'b0;
        tick();
        check("err_clear", cfg_err_o, 0);
        set_cfg(1, 16, 2, 0);
        en_i = 1'b1;
        tick();
        check("err_div1", cfg_err_o, 1);
        en_i = 1'b0;
        tick();
        set_cfg(8, 7, 2, 0);
        en_i = 1'b1;
        tick();
        check("err_sb7", cfg_err_o, 1);
        en_i = 1'b0;
        tick();
        set_cfg(8, 16, 2, 3);
        en_i = 1'b1;
        tick();
        check("err_mode3", cfg_err_o, 1);
        en_i = 1'b0;
        tick();
        set_cfg(8, 16, 3, 2);
        en_i = 1'b1;
        tick();
        check("dsp_ns3_busy", busy_o, 1);
        check("dsp_ns3_err", cfg_err_o, 0);

        // mid-frame changes apply only at frame boundaries
        do_reset();
        set_cfg(4, 8, 2, 0);
        en_i = 1'b1;
        tick();
        repeat (10) tick();
        div_i = DIV_W'(6);
        measure_frame(n);
        check("midchg_old_div", n, 54);
        repeat (10) tick();
        num_slots_i = NS_W'(3);
        measure_frame(n);
        check("midchg_new_div", n, 86);
        check("run_bad_cfg_err", cfg_err_o, 1);
        check("run_bad_cfg_busy", busy_o, 1);
        measure_frame(n);
        check("run_bad_cfg_keep", n, 96);

        // async reset during an SCK-high cycle
        do_reset();
        set_cfg(8, 32, 2, 1);
        en_i = 1'b1;
        tick();
        repeat (20) tick();
        check("arst_pre_sck", sck_o, 1);
        #2;
        rst  = 1'b1;
        en_i = 1'b0;
        #1;
        check("arst_sck", sck_o, 0);
        check("arst_fs", fs_o, 1);
        check("arst_busy", busy_o, 0);
        check("arst_bit", bit_idx_o, 0);
        check("arst_slot", slot_idx_o, 0);
        check("arst_fall", sck_fall_o, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_stay_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
